// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//   Immediate-extension stage with a valid/ready handshake on both sides.
//   Each accepted request is decoded by mode (zero/sign extension, branch
//   offset, upper immediate) and lands in an output register. A skid register
//   absorbs one request while the output is stalled, so in_ready comes
//   straight from state and never depends combinationally on out_ready.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request present          in_ready  : request can be taken
//   in_imm     : raw immediate            in_shamt  : raw shift amount
//   in_mode    : extension mode (0..4 legal, 5..7 illegal)
//   in_tag     : sideband carried unchanged to out_tag
//   flush      : drop held and incoming requests
//   out_valid  : out_data/out_tag/out_err valid
//   out_ready  : downstream consumes output this cycle
//   out_data   : extended value           out_tag   : tag of that value
//   out_err    : request had illegal mode
//   err_cnt    : saturating count of accepted illegal-mode requests
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err,
    output logic [7:0]         err_cnt
);

    localparam logic [2:0] MODE_ZSHAMT = 3'd0;
    localparam logic [2:0] MODE_ZIMM   = 3'd1;
    localparam logic [2:0] MODE_SIMM   = 3'd2;
    localparam logic [2:0] MODE_BROFF  = 3'd3;
    localparam logic [2:0] MODE_LUI    = 3'd4;

    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_ext_data;
    logic              w_ext_err;
    logic              w_accept;
    logic              w_main_free;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [TAG_W-1:0]  r_main_tag;
    logic              r_main_err;

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_err;

    logic [7:0]        r_err_cnt;

    // Mode decode. BROFF and LUI both start from the sign-extended immediate;
    // shifting it keeps the sign in every bit above the placed field.
    always_comb begin
        w_simm     = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
        w_ext_data = '0;
        w_ext_err  = 1'b0;
        case (in_mode)
            MODE_ZSHAMT: w_ext_data = {{(DATA_W-SHAMT_W){1'b0}}, in_shamt};
            MODE_ZIMM:   w_ext_data = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            MODE_SIMM:   w_ext_data = w_simm;
            MODE_BROFF:  w_ext_data = w_simm << 2;
            MODE_LUI:    w_ext_data = w_simm << 16;
            default:     w_ext_err  = 1'b1;
        endcase
    end

    // A full skid means in_ready is low, so no accept can coincide with it.
    assign w_accept    = in_valid && !r_skid_valid && !flush;
    assign w_main_free = !r_main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_tag   <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_tag   <= '0;
            r_skid_err   <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (r_skid_valid) begin
                // Main is necessarily full here; drain skid into it on consume.
                if (out_ready) begin
                    r_main_data  <= r_skid_data;
                    r_main_tag   <= r_skid_tag;
                    r_main_err   <= r_skid_err;
                    r_skid_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (w_main_free) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= w_ext_data;
                    r_main_tag   <= in_tag;
                    r_main_err   <= w_ext_err;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_ext_data;
                    r_skid_tag   <= in_tag;
                    r_skid_err   <= w_ext_err;
                end
            end else if (r_main_valid && out_ready) begin
                r_main_valid <= 1'b0;
            end

            if (w_accept && w_ext_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_tag   = r_main_tag;
    assign out_err   = r_main_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
//   Drives a 32-bit and a 64-bit instance with identical stimulus. A queue
//   scoreboard holds the expected contents of main+skid; occupancy predicts
//   in_ready/out_valid, the head predicts the outputs, and a saturating
//   counter predicts err_cnt.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_imm;
    logic [4:0]  in_shamt;
    logic [2:0]  in_mode;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_data32;
    logic [4:0]  out_tag32;
    logic [7:0]  err_cnt32;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_data64;
    logic [4:0]  out_tag64;
    logic [7:0]  err_cnt64;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   exp_err_cnt;

    imm_ext_pipe #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_imm(in_imm), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_tag(out_tag32), .out_err(out_err32),
        .err_cnt(err_cnt32)
    );

    imm_ext_pipe #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_imm(in_imm), .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .out_data(out_data64), .out_tag(out_tag64), .out_err(out_err64),
        .err_cnt(err_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] m, input logic [15:0] imm,
                                          input logic [4:0] sh);
        logic [63:0] s;
        s = {{48{imm[15]}}, imm};
        case (m)
            3'd0:    return {59'd0, sh};
            3'd1:    return {48'd0, imm};
            3'd2:    return s;
            3'd3:    return s << 2;
            3'd4:    return s << 16;
            default: return 64'd0;
        endcase
    endfunction

    // Monitor at the falling edge: outputs reflect the last rising edge and
    // inputs are those the next rising edge will see.
    always @(negedge clk) begin
        int   sz;
        logic rdy;
        logic ovld;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_err_cnt = 0;
            chk_eq("rst_out_valid32", out_valid32, 0);
            chk_eq("rst_out_valid64", out_valid64, 0);
            chk_eq("rst_in_ready", in_ready32, 1);
            chk_eq("rst_err_cnt", err_cnt32, 0);
        end else begin
            sz   = sb.size();
            rdy  = (sz < 2);
            ovld = (sz > 0);
            chk_eq("in_ready32", in_ready32, rdy);
            chk_eq("in_ready64", in_ready64, rdy);
            chk_eq("out_valid32", out_valid32, ovld);
            chk_eq("out_valid64", out_valid64, ovld);
            chk_eq("err_cnt32", err_cnt32, exp_err_cnt);
            chk_eq("err_cnt64", err_cnt64, exp_err_cnt);
            if (ovld) begin
                e = sb[0];
                chk_eq("out_data32", {32'd0, out_data32}, {32'd0, e.d[31:0]});
                chk_eq("out_data64", out_data64, e.d);
                chk_eq("out_tag", out_tag32, e.tag);
                chk_eq("out_tag64", out_tag64, e.tag);
                chk_eq("out_err", out_err32, e.err);
                chk_eq("out_err64", out_err64, e.err);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (ovld && out_ready) void'(sb.pop_front());
                if (in_valid && rdy) begin
                    e.d   = model(in_mode, in_imm, in_shamt);
                    e.tag = in_tag;
                    e.err = (in_mode > 3'd4);
                    sb.push_back(e);
                    if (e.err && exp_err_cnt < 255) exp_err_cnt++;
                end
            end
        end
    end

    // Present inputs for one rising edge and return 1 time unit after it.
    task automatic step(input logic v, input logic [2:0] m, input logic [15:0] imm,
                        input logic [4:0] sh, input logic [4:0] tg,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_mode   = m;
        in_imm    = imm;
        in_shamt  = sh;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cnt_before;
        n_vec = 0;
        n_err = 0;
        exp_err_cnt = 0;
        rst_n = 1'b0;
        in_valid = 0; in_imm = 0; in_shamt = 0; in_mode = 0; in_tag = 0;
        flush = 0; out_ready = 0;
        #2;
        chk_eq("reset_out_data", out_data32, 0);
        chk_eq("reset_out_tag", out_tag32, 0);
        chk_eq("reset_out_err", out_err32, 0);
        chk_eq("reset_in_ready", in_ready32, 1);
        chk_eq("reset_err_cnt", err_cnt64, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sign extension, 32-bit
        step(1, 3'd2, 16'h8001, 5'd0, 5'd3, 1, 0);
        chk_eq("simm_8001", out_data32, 32'hFFFF8001);
        chk_eq("simm_err", out_err32, 0);
        chk_eq("simm_valid", out_valid32, 1);
        // Upper immediate and branch offset, 64-bit
        step(1, 3'd4, 16'h8000, 5'd0, 5'd4, 1, 0);
        chk_eq("lui_8000_64", out_data64, 64'hFFFFFFFF80000000);
        chk_eq("lui_8000_32", out_data32, 32'h80000000);
        step(1, 3'd3, 16'h0004, 5'd0, 5'd5, 1, 0);
        chk_eq("broff_4_64", out_data64, 64'h10);
        step(1, 3'd0, 16'hFFFF, 5'd31, 5'd6, 1, 0);
        chk_eq("zshamt_31", out_data64, 64'd31);
        step(1, 3'd1, 16'hF00F, 5'd0, 5'd7, 1, 0);
        chk_eq("zimm_f00f", out_data64, 64'h000000000000F00F);
        step(0, 3'd0, 16'h0, 5'd0, 5'd0, 1, 0);

        // Stall: tag 1 to main, tag 2 to skid
        step(1, 3'd1, 16'h0011, 5'd0, 5'd1, 0, 0);
        chk_eq("stall_ready_after_1", in_ready32, 1);
        step(1, 3'd1, 16'h0022, 5'd0, 5'd2, 0, 0);
        chk_eq("stall_ready_after_2", in_ready32, 0);
        chk_eq("stall_hold_tag", out_tag32, 1);
        // Consume with skid full: tag 9 must not be accepted
        step(1, 3'd1, 16'h0099, 5'd0, 5'd9, 1, 0);
        chk_eq("drain_tag2", out_tag32, 2);
        chk_eq("drain_ready", in_ready32, 1);
        step(0, 3'd1, 16'h0, 5'd0, 5'd0, 1, 0);
        chk_eq("drain_empty", out_valid32, 0);

        // Flush with skid full and a request presented
        step(1, 3'd7, 16'h0, 5'd0, 5'd10, 0, 0);
        step(1, 3'd6, 16'h0, 5'd0, 5'd11, 0, 0);
        cnt_before = err_cnt32;
        step(1, 3'd5, 16'h0, 5'd0, 5'd12, 0, 1);
        chk_eq("flush_valid", out_valid32, 0);
        chk_eq("flush_ready", in_ready32, 1);
        chk_eq("flush_err_cnt", err_cnt32, cnt_before);
        // Flush with room available: illegal request still dropped, not counted
        step(1, 3'd7, 16'h0, 5'd0, 5'd13, 1, 1);
        chk_eq("flush_drop_valid", out_valid32, 0);
        chk_eq("flush_drop_cnt", err_cnt32, cnt_before);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 16'($urandom), 5'($urandom), 5'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        step(0, 3'd0, 16'h0, 5'd0, 5'd0, 1, 0);
        step(0, 3'd0, 16'h0, 5'd0, 5'd0, 1, 0);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            step(1, 3'd7, 16'($urandom), 5'd0, 5'(i), 1, 0);
        end
        chk_eq("err_cnt_sat32", err_cnt32, 8'd255);
        chk_eq("err_cnt_sat64", err_cnt64, 8'd255);
        chk_eq("sat_out_data", out_data64, 64'd0);
        chk_eq("sat_out_err", out_err64, 1);

        // Asynchronous reset mid-stream with skid full
        step(1, 3'd2, 16'h1234, 5'd0, 5'd20, 0, 0);
        step(1, 3'd2, 16'h5678, 5'd0, 5'd21, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("async_out_valid", out_valid32, 0);
        chk_eq("async_in_ready", in_ready64, 1);
        chk_eq("async_out_data", out_data64, 0);
        chk_eq("async_out_tag", out_tag32, 0);
        chk_eq("async_out_err", out_err32, 0);
        chk_eq("async_err_cnt", err_cnt32, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First accept after reset behaves as from empty
        step(1, 3'd2, 16'hFFFE, 5'd0, 5'd22, 0, 0);
        chk_eq("post_rst_data", out_data32, 32'hFFFFFFFE);
        chk_eq("post_rst_tag", out_tag32, 22);
        chk_eq("post_rst_ready", in_ready32, 1);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)),
                 16'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b0);
        end
        step(0, 3'd0, 16'h0, 5'd0, 5'd0, 1, 0);
        step(0, 3'd0, 16'h0, 5'd0, 5'd0, 1, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
